// File: rtl/armleocpu_ptw_arbiter.sv
// rtl/armleocpu_ptw_arbiter.sv - round-robin arbiter sharing one page-table walker between TLB requesters
// Holds the walk request stable until the walker finishes and returns its result as a one-cycle response.
module armleocpu_ptw_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [20*NUM_REQ-1:0]   req_vaddr,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic                    rsp_pagefault,
  output logic                    rsp_accessfault,
  output logic [7:0]              rsp_access_bits,
  output logic [21:0]             rsp_physical_address,
  output logic                    ptw_resolve_request,
  output logic [31:0]             ptw_resolve_virtual_address,
  input  logic                    ptw_resolve_done,
  input  logic                    ptw_resolve_pagefault,
  input  logic                    ptw_resolve_accessfault,
  input  logic [7:0]              ptw_resolve_access_bits,
  input  logic [21:0]             ptw_resolve_physical_address
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            drop_q, drop_d;
  logic [19:0]     vpn_q, vpn_d;
  logic            pf_q, pf_d;
  logic            af_q, af_d;
  logic [7:0]      bits_q, bits_d;
  logic [21:0]     ppn_q, ppn_d;

  logic [19:0]     vpn_slot [NUM_REQ];
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW:0]     cand;
  logic [IW-1:0]   rr_next;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vpn_slot[i] = req_vaddr[20*i +: 20];
    end
  end

  // Scan upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!sel_found && req_valid[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  assign rr_next = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    vpn_d   = vpn_q;
    pf_d    = pf_q;
    af_d    = af_q;
    bits_d  = bits_q;
    ppn_d   = ppn_q;
    case (state_q)
      S_IDLE: begin
        if (!flush && sel_found) begin
          idx_d   = sel_idx;
          vpn_d   = vpn_slot[sel_idx];
          rr_d    = rr_next;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        // The walker cannot be cancelled, so a flush only marks the result as stale.
        if (flush) begin
          drop_d = 1'b1;
        end
        if (ptw_resolve_done) begin
          pf_d    = ptw_resolve_pagefault;
          af_d    = ptw_resolve_accessfault;
          bits_d  = ptw_resolve_access_bits;
          ppn_d   = ptw_resolve_physical_address;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      vpn_q   <= '0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      bits_q  <= '0;
      ppn_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      vpn_q   <= vpn_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
      bits_q  <= bits_d;
      ppn_q   <= ppn_d;
    end
  end

  always_comb begin
    req_grant = '0;
    rsp_done  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_grant[i] = (state_q != S_IDLE) && (idx_q == IW'(i));
      rsp_done[i]  = (state_q == S_RESP) && !drop_q && !flush && (idx_q == IW'(i));
    end
  end

  assign ptw_resolve_request         = (state_q == S_WALK);
  assign ptw_resolve_virtual_address = {vpn_q, 12'h000};
  assign rsp_pagefault               = pf_q;
  assign rsp_accessfault             = af_q;
  assign rsp_access_bits             = bits_q;
  assign rsp_physical_address        = ppn_q;

endmodule

// File: tb/tb_armleocpu_ptw_arbiter.sv
// tb/tb_armleocpu_ptw_arbiter.sv - directed vector bench for the page-table walker arbiter
// Each vector drives inputs for one cycle and lists the outputs expected during that cycle.
module tb_armleocpu_ptw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [39:0] req_vaddr = '0;
  logic [1:0]  req_grant;
  logic [1:0]  rsp_done;
  logic        rsp_pagefault;
  logic        rsp_accessfault;
  logic [7:0]  rsp_access_bits;
  logic [21:0] rsp_physical_address;
  logic        ptw_resolve_request;
  logic [31:0] ptw_resolve_virtual_address;
  logic        ptw_resolve_done = 1'b0;
  logic        ptw_resolve_pagefault = 1'b0;
  logic        ptw_resolve_accessfault = 1'b0;
  logic [7:0]  ptw_resolve_access_bits = '0;
  logic [21:0] ptw_resolve_physical_address = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  armleocpu_ptw_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .req_valid(req_valid),
    .req_vaddr(req_vaddr),
    .req_grant(req_grant),
    .rsp_done(rsp_done),
    .rsp_pagefault(rsp_pagefault),
    .rsp_accessfault(rsp_accessfault),
    .rsp_access_bits(rsp_access_bits),
    .rsp_physical_address(rsp_physical_address),
    .ptw_resolve_request(ptw_resolve_request),
    .ptw_resolve_virtual_address(ptw_resolve_virtual_address),
    .ptw_resolve_done(ptw_resolve_done),
    .ptw_resolve_pagefault(ptw_resolve_pagefault),
    .ptw_resolve_accessfault(ptw_resolve_accessfault),
    .ptw_resolve_access_bits(ptw_resolve_access_bits),
    .ptw_resolve_physical_address(ptw_resolve_physical_address)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  rv;
    logic [19:0] v0;
    logic [19:0] v1;
    logic        fl;
    logic        dn;
    logic        pf;
    logic        af;
    logic [7:0]  bits;
    logic [21:0] ppn;
    logic        e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_grant;
    logic [1:0]  e_done;
    logic        e_pf;
    logic        e_af;
    logic [7:0]  e_bits;
    logic [21:0] e_ppn;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(
    input logic r, input logic [1:0] rv, input logic [19:0] v0, input logic [19:0] v1,
    input logic fl, input logic dn, input logic pf, input logic af, input logic [7:0] bits,
    input logic [21:0] ppn, input logic e_req, input logic [31:0] e_addr, input logic [1:0] e_grant,
    input logic [1:0] e_done, input logic e_pf, input logic e_af, input logic [7:0] e_bits,
    input logic [21:0] e_ppn);
    vec_t v;
    v = '{r, rv, v0, v1, fl, dn, pf, af, bits, ppn, e_req, e_addr, e_grant, e_done, e_pf, e_af, e_bits, e_ppn};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(
    input logic r, input logic [1:0] rv, input logic [19:0] a0, input logic [19:0] a1,
    input logic fl, input logic dn, input logic p, input logic a, input logic [7:0] b,
    input logic [21:0] pp);
    @(negedge clk);
    rst                          = r;
    req_valid                    = rv;
    req_vaddr                    = {a1, a0};
    flush                        = fl;
    ptw_resolve_done             = dn;
    ptw_resolve_pagefault        = p;
    ptw_resolve_accessfault      = a;
    ptw_resolve_access_bits      = b;
    ptw_resolve_physical_address = pp;
    #1;
  endtask

  task automatic idle_cyc(input logic r, input logic [1:0] rv, input logic [19:0] a0,
                          input logic [19:0] a1, input logic fl, input logic dn);
    drive(r, rv, a0, a1, fl, dn, 1'b0, 1'b0, 8'h77, 22'h000011);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    // Basic walk on port 0.
    tbl[0]  = mk(1, 2'b00, 20'h0, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[1]  = mk(0, 2'b01, 20'h00C01, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[2]  = mk(0, 2'b01, 20'h00C01, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 1, 32'h00C01000, 2'b01, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[3]  = mk(0, 2'b01, 20'h00C01, 20'h0, 0, 1, 0, 0, 8'h0F, 22'h000401, 1, 32'h00C01000, 2'b01, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[4]  = mk(0, 2'b01, 20'h00C01, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b01, 2'b01, 0, 0, 8'h0F, 22'h000401);
    tbl[5]  = mk(0, 2'b00, 20'h00C01, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    // Both ports request right after reset: port 0 then port 1.
    tbl[6]  = mk(1, 2'b00, 20'h0, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[7]  = mk(0, 2'b11, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[8]  = mk(0, 2'b11, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 1, 32'h11111000, 2'b01, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[9]  = mk(0, 2'b11, 20'h11111, 20'h22222, 0, 1, 0, 1, 8'hC3, 22'h3AAAA, 1, 32'h11111000, 2'b01, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[10] = mk(0, 2'b11, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b01, 2'b01, 0, 1, 8'hC3, 22'h3AAAA);
    tbl[11] = mk(0, 2'b10, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[12] = mk(0, 2'b10, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 1, 32'h22222000, 2'b10, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[13] = mk(0, 2'b10, 20'h11111, 20'h22222, 0, 1, 1, 1, 8'h5A, 22'h00123, 1, 32'h22222000, 2'b10, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[14] = mk(0, 2'b10, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b10, 2'b10, 1, 1, 8'h5A, 22'h00123);
    tbl[15] = mk(0, 2'b00, 20'h11111, 20'h22222, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    // Megapage-misaligned walk ending in page fault.
    tbl[16] = mk(0, 2'b01, 20'h80401, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[17] = mk(0, 2'b01, 20'h80401, 20'h0, 0, 1, 1, 0, 8'h0F, 22'h0, 1, 32'h80401000, 2'b01, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[18] = mk(0, 2'b01, 20'h80401, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b01, 2'b01, 1, 0, 8'h0F, 22'h0);
    tbl[19] = mk(0, 2'b00, 20'h80401, 20'h0, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    // Flush during the response cycle suppresses rsp_done.
    tbl[20] = mk(0, 2'b10, 20'h0, 20'h33333, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[21] = mk(0, 2'b10, 20'h0, 20'h33333, 0, 1, 0, 0, 8'h01, 22'h1, 1, 32'h33333000, 2'b10, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[22] = mk(0, 2'b10, 20'h0, 20'h33333, 1, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b10, 2'b00, 0, 0, 8'h00, 22'h0);
    tbl[23] = mk(0, 2'b00, 20'h0, 20'h33333, 0, 0, 0, 0, 8'h00, 22'h0, 0, 32'h0, 2'b00, 2'b00, 0, 0, 8'h00, 22'h0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].rv, tbl[i].v0, tbl[i].v1, tbl[i].fl, tbl[i].dn,
            tbl[i].pf, tbl[i].af, tbl[i].bits, tbl[i].ppn);
      chk($sformatf("v%0d req", i), 32'(ptw_resolve_request), 32'(tbl[i].e_req));
      chk($sformatf("v%0d grant", i), 32'(req_grant), 32'(tbl[i].e_grant));
      chk($sformatf("v%0d done", i), 32'(rsp_done), 32'(tbl[i].e_done));
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d addr", i), ptw_resolve_virtual_address, tbl[i].e_addr);
      end
      if (tbl[i].rst || tbl[i].e_done != 2'b00) begin
        chk($sformatf("v%0d pf", i), 32'(rsp_pagefault), 32'(tbl[i].e_pf));
        chk($sformatf("v%0d af", i), 32'(rsp_accessfault), 32'(tbl[i].e_af));
        chk($sformatf("v%0d bits", i), 32'(rsp_access_bits), 32'(tbl[i].e_bits));
        chk($sformatf("v%0d ppn", i), 32'(rsp_physical_address), 32'(tbl[i].e_ppn));
      end
    end

    // Four back-to-back walks with both ports requesting: grants alternate 0,1,0,1.
    idle_cyc(1, 2'b00, 20'h0, 20'h0, 0, 0);
    for (int w = 0; w < 4; w++) begin
      gap = 0;
      for (int t = 0; t < 8; t++) begin
        idle_cyc(0, 2'b11, 20'h0AAAA, 20'h0BBBB, 0, 0);
        if (ptw_resolve_request) break;
        gap++;
      end
      chk($sformatf("s3 w%0d req", w), 32'(ptw_resolve_request), 32'd1);
      chk($sformatf("s3 w%0d gap", w), 32'(gap), 32'd1);
      chk($sformatf("s3 w%0d grant", w), 32'(req_grant), (w % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("s3 w%0d addr", w), ptw_resolve_virtual_address,
          (w % 2 == 0) ? 32'h0AAAA000 : 32'h0BBBB000);
      idle_cyc(0, 2'b11, 20'h0AAAA, 20'h0BBBB, 0, 1);
      idle_cyc(0, 2'b11, 20'h0AAAA, 20'h0BBBB, 0, 0);
      chk($sformatf("s3 w%0d done", w), 32'(rsp_done), (w % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("s3 w%0d req low", w), 32'(ptw_resolve_request), 32'd0);
    end

    // Flush in IDLE blocks the grant; flush mid-walk on port 1 drops the result.
    idle_cyc(1, 2'b00, 20'h0, 20'h0, 0, 0);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 1, 0);
    chk("s4 idle flush req", 32'(ptw_resolve_request), 32'd0);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 0, 0);
    chk("s4 blocked req", 32'(ptw_resolve_request), 32'd0);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 0, 0);
    chk("s4 walk req", 32'(ptw_resolve_request), 32'd1);
    chk("s4 walk grant", 32'(req_grant), 32'd2);
    chk("s4 walk addr", ptw_resolve_virtual_address, 32'h0ABCD000);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 1, 0);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 0, 0);
    chk("s4 held req", 32'(ptw_resolve_request), 32'd1);
    chk("s4 held addr", ptw_resolve_virtual_address, 32'h0ABCD000);
    idle_cyc(0, 2'b10, 20'h0, 20'h0ABCD, 0, 1);
    idle_cyc(0, 2'b01, 20'h05555, 20'h0ABCD, 0, 0);
    chk("s4 dropped done", 32'(rsp_done), 32'd0);
    chk("s4 resp grant", 32'(req_grant), 32'd2);
    idle_cyc(0, 2'b01, 20'h05555, 20'h0ABCD, 0, 0);
    chk("s4 idle req", 32'(ptw_resolve_request), 32'd0);
    chk("s4 idle grant", 32'(req_grant), 32'd0);
    idle_cyc(0, 2'b01, 20'h05555, 20'h0ABCD, 0, 0);
    chk("s4 regrant", 32'(req_grant), 32'd1);
    chk("s4 regrant addr", ptw_resolve_virtual_address, 32'h05555000);
    drive(0, 2'b01, 20'h05555, 20'h0ABCD, 0, 1, 0, 0, 8'h77, 22'h000011);
    idle_cyc(0, 2'b01, 20'h05555, 20'h0ABCD, 0, 0);
    chk("s4 regrant done", 32'(rsp_done), 32'd1);
    chk("s4 regrant bits", 32'(rsp_access_bits), 32'h77);

    // Asynchronous reset mid-walk clears everything without a clock edge.
    idle_cyc(0, 2'b01, 20'h12345, 20'h0FEDC, 0, 0);
    idle_cyc(0, 2'b01, 20'h12345, 20'h0FEDC, 0, 0);
    chk("s6 walk req", 32'(ptw_resolve_request), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6 rst req", 32'(ptw_resolve_request), 32'd0);
    chk("s6 rst grant", 32'(req_grant), 32'd0);
    chk("s6 rst done", 32'(rsp_done), 32'd0);
    chk("s6 rst addr", ptw_resolve_virtual_address, 32'd0);
    chk("s6 rst bits", 32'(rsp_access_bits), 32'd0);
    chk("s6 rst ppn", 32'(rsp_physical_address), 32'd0);
    idle_cyc(0, 2'b10, 20'h12345, 20'h0FEDC, 0, 0);
    chk("s6 post idle req", 32'(ptw_resolve_request), 32'd0);
    idle_cyc(0, 2'b10, 20'h12345, 20'h0FEDC, 0, 0);
    chk("s6 post grant", 32'(req_grant), 32'd2);
    chk("s6 post addr", ptw_resolve_virtual_address, 32'h0FEDC000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
